res_wr_ctrl: RTL and testbench

- Sequencer and write-port arbiter for the residual register file in the OMP processor.
- Two streaming sources share the single file write port:
  - init: measurement vector y, streamed from ROM at the start of a solve.
  - upd: updated residual r, from the residual-update datapath after each iteration.
- Block generates wr_addr/wr_en/wr_data for one full-vector write, then issues a one-cycle rd_en so the file's packed Q output captures the new vector, then flags completion.

---
 rtl/res_wr_ctrl.sv | 129 ++++++++++++
 tb/tb_res_wr_ctrl.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/res_wr_ctrl.sv
// Residual register file write sequencer: arbitrates the init (y) and upd (r) streams
// onto the single write port, then snapshots the file and reports completion.
module res_wr_ctrl #(
    parameter int DATA_W = 16,
    parameter int SIZE   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_start,
    input  logic              upd_start,
    input  logic              abort,
    input  logic              init_valid,
    input  logic [DATA_W-1:0] init_data,
    output logic              init_ready,
    input  logic              upd_valid,
    input  logic [DATA_W-1:0] upd_data,
    output logic              upd_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    output logic              res_valid,
    output logic              res_src,
    output logic              busy,
    output logic [7:0]        iter_cnt
);

    // state  | meaning
    // IDLE   | no job; dispatch pending init first, then pending upd
    // LOAD_I | streaming y from ROM into addresses 0..SIZE-1
    // LOAD_U | streaming updated residual into addresses 0..SIZE-1
    // WAIT   | final write beat in flight
    // SNAP   | rd_en strobe: file Q captures the new vector
    // DONE   | res_valid pulse with res_src
    typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_U, WAIT, SNAP, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SIZE - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              pend_i;
    logic              pend_u;
    logic              src;
    logic              accept;
    logic [DATA_W-1:0] sample;

    assign init_ready = (state == LOAD_I);
    assign upd_ready  = (state == LOAD_U);
    assign busy       = (state != IDLE);
    assign accept     = (init_valid && init_ready) || (upd_valid && upd_ready);
    assign sample     = (state == LOAD_U) ? upd_data : init_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pend_i    <= 1'b0;
            pend_u    <= 1'b0;
            src       <= 1'b0;
            wr_addr   <= '0;
            wr_en     <= 1'b0;
            wr_data   <= '0;
            rd_en     <= 1'b0;
            res_valid <= 1'b0;
            res_src   <= 1'b0;
            iter_cnt  <= '0;
        end else begin
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            res_valid <= 1'b0;
            pend_i    <= pend_i | init_start;
            pend_u    <= pend_u | upd_start;

            // A sample accepted in an abort cycle is still written; only the snapshot is lost.
            if (accept) begin
                wr_en   <= 1'b1;
                wr_addr <= cnt;
                wr_data <= sample;
                cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end

            if (abort) begin
                state  <= IDLE;
                cnt    <= '0;
                pend_i <= 1'b0;
                pend_u <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (pend_i || init_start) begin
                            state  <= LOAD_I;
                            pend_i <= 1'b0;
                            src    <= 1'b0;
                        end else if (pend_u || upd_start) begin
                            state  <= LOAD_U;
                            pend_u <= 1'b0;
                            src    <= 1'b1;
                        end
                    end
                    LOAD_I, LOAD_U: begin
                        if (accept && cnt == LAST)
                            state <= WAIT;
                    end
                    WAIT: begin
                        state <= SNAP;
                        rd_en <= 1'b1;
                    end
                    SNAP: begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        res_src   <= src;
                        if (!src)
                            iter_cnt <= '0;
                        else if (iter_cnt != 8'hFF)
                            iter_cnt <= iter_cnt + 8'd1;
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_res_wr_ctrl.sv
// Bench for res_wr_ctrl: random streams checked against a queue-based model of the
// write port, a register-file model with snapshot, and an iteration counter model.
module tb_res_wr_ctrl;
    localparam int DATA_W = 16;
    localparam int SIZE   = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              init_start = 1'b0, upd_start = 1'b0, abort = 1'b0;
    logic              init_valid = 1'b0, upd_valid = 1'b0;
    logic [DATA_W-1:0] init_data = '0, upd_data = '0;
    logic              init_ready, upd_ready, wr_en, rd_en, res_valid, res_src, busy;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [7:0]        iter_cnt;

    always #5 clk = ~clk;

    res_wr_ctrl #(.DATA_W(DATA_W), .SIZE(SIZE), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .init_start(init_start), .upd_start(upd_start), .abort(abort),
        .init_valid(init_valid), .init_data(init_data), .init_ready(init_ready),
        .upd_valid(upd_valid), .upd_data(upd_data), .upd_ready(upd_ready),
        .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .res_valid(res_valid), .res_src(res_src), .busy(busy), .iter_cnt(iter_cnt));

    typedef struct packed {logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d;} wr_t;

    int errs = 0, checks = 0, cyc = 0, iter_model = 0;
    logic [DATA_W-1:0] jd [SIZE];
    logic [DATA_W-1:0] mem [SIZE];
    logic [DATA_W-1:0] q_snap [SIZE];
    wr_t wq[$];
    int rd_cnt = 0, rv_cnt = 0, rd_cyc = 0, rv_cyc = 0, last_acc_cyc = 0;
    int first_wr_cyc = 0, last_wr_cyc = 0, excl_viol = 0, follow_viol = 0;
    int urdy_cnt = 0, urdy_rise_cyc = -1;
    logic rv_src = 1'b0, prev_acc = 1'b0, prev_urdy = 1'b0;

    always @(posedge clk) cyc++;

    // Passive observer: the register file model, snapshot on rd_en, and event timestamps.
    always @(negedge clk) begin
        if (rst) begin
            prev_acc  = 1'b0;
            prev_urdy = 1'b0;
        end else begin
            if ((int'(wr_en) + int'(rd_en) + int'(res_valid)) > 1) excl_viol++;
            if (wr_en !== prev_acc) follow_viol++;
            if (wr_en) begin
                if (wq.size() == 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                wq.push_back({wr_addr, wr_data});
                mem[wr_addr] = wr_data;
            end
            if (rd_en) begin rd_cnt++; rd_cyc = cyc; q_snap = mem; end
            if (res_valid) begin rv_cnt++; rv_cyc = cyc; rv_src = res_src; end
            if (upd_ready) urdy_cnt++;
            if (upd_ready && !prev_urdy) urdy_rise_cyc = cyc;
            prev_urdy = upd_ready;
            prev_acc = (init_valid && init_ready) || (upd_valid && upd_ready);
            if (prev_acc) last_acc_cyc = cyc;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks start and end at #1 after a rising edge.
    task automatic pulse(input logic i, input logic u, input logic ab);
        init_start = i; upd_start = u; abort = ab;
        @(posedge clk); #1;
        init_start = 1'b0; upd_start = 1'b0; abort = 1'b0;
    endtask

    task automatic stream(input logic src, input int mode, input int nbeats, output logic to);
        int idx = 0;
        int k = 0;
        logic v;
        to = 1'b0;
        while (idx < nbeats) begin
            if (k >= 400) begin to = 1'b1; break; end
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ((k % 2) == 0) : 1'($urandom_range(0, 1));
            if (src) begin upd_valid = v; upd_data = jd[idx]; end
            else begin init_valid = v; init_data = jd[idx]; end
            @(negedge clk);
            if (v && (src ? upd_ready : init_ready)) idx++;
            @(posedge clk); #1;
            k++;
        end
        init_valid = 1'b0;
        upd_valid  = 1'b0;
    endtask

    task automatic wait_done(output logic to);
        int n = 0;
        int start = rv_cnt;
        while (rv_cnt == start && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        to = (rv_cnt == start);
    endtask

    task automatic rand_data();
        for (int i = 0; i < SIZE; i++) jd[i] = DATA_W'($urandom);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({wr_en, rd_en, res_valid, res_src, busy, init_ready, upd_ready} !== 7'b0) begin
            errs++; $display("FAIL reset_flags: got %b want 0000000",
                {wr_en, rd_en, res_valid, res_src, busy, init_ready, upd_ready});
        end
        checks++;
        if ({wr_addr, wr_data, iter_cnt} !== '0) begin
            errs++; $display("FAIL reset_values: got addr=%0d data=%0h iter=%0d want 0", wr_addr, wr_data, iter_cnt);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errs++; $display("FAIL reset_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_init_job();
        logic to, to2;
        int r0, v0;
        for (int i = 0; i < SIZE; i++) jd[i] = DATA_W'(i + 1);
        wq.delete(); r0 = rd_cnt; v0 = rv_cnt;
        pulse(1'b1, 1'b0, 1'b0);
        stream(1'b0, 0, SIZE, to);
        wait_done(to2);
        iter_model = 0;
        checks++;
        if (to || to2) begin errs++; $display("FAIL init_timeout: got stream=%b done=%b want 0 0", to, to2); end
        checks++;
        if (wq.size() != SIZE) begin errs++; $display("FAIL init_wr_count: got %0d want %0d", wq.size(), SIZE); end
        for (int i = 0; i < SIZE && i < wq.size(); i++) begin
            checks++;
            if ({wq[i].a, wq[i].d} !== {ADDR_W'(i), jd[i]}) begin
                errs++; $display("FAIL init_write[%0d]: got addr=%0d data=%0h want addr=%0d data=%0h", i, wq[i].a, wq[i].d, i, jd[i]);
            end
        end
        checks++;
        if (last_wr_cyc - first_wr_cyc != SIZE - 1) begin
            errs++; $display("FAIL init_consecutive: got span=%0d want %0d", last_wr_cyc - first_wr_cyc, SIZE - 1);
        end
        checks++;
        if (rd_cnt - r0 != 1 || rd_cyc != last_acc_cyc + 2) begin
            errs++; $display("FAIL init_rd_en: got count=%0d lag=%0d want 1 2", rd_cnt - r0, rd_cyc - last_acc_cyc);
        end
        checks++;
        if (rv_cnt - v0 != 1 || rv_cyc != last_acc_cyc + 3 || rv_src !== 1'b0) begin
            errs++; $display("FAIL init_res_valid: got count=%0d lag=%0d src=%b want 1 3 0", rv_cnt - v0, rv_cyc - last_acc_cyc, rv_src);
        end
        for (int i = 0; i < SIZE; i++) begin
            checks++;
            if (q_snap[i] !== DATA_W'(i + 1)) begin
                errs++; $display("FAIL init_q[%0d]: got %0h want %0h", i, q_snap[i], i + 1);
            end
        end
        checks++;
        if (iter_cnt !== 8'(iter_model) || busy !== 1'b0) begin
            errs++; $display("FAIL init_end_state: got iter=%0d busy=%b want %0d 0", iter_cnt, busy, iter_model);
        end
    endtask

    task automatic test_priority();
        logic to, to2;
        int u0, init_rv;
        rand_data();
        wq.delete(); u0 = urdy_cnt;
        pulse(1'b1, 1'b1, 1'b0);
        stream(1'b0, 0, SIZE, to);
        wait_done(to2);
        checks++;
        if (to || to2 || rv_src !== 1'b0) begin
            errs++; $display("FAIL prio_init_first: got timeout=%b src=%b want 0 0", to | to2, rv_src);
        end
        checks++;
        if (urdy_cnt != u0) begin errs++; $display("FAIL prio_upd_ready: got %0d upd_ready cycles want 0", urdy_cnt - u0); end
        checks++;
        if (wq.size() != SIZE || wq[SIZE-1] !== {ADDR_W'(SIZE - 1), jd[SIZE-1]}) begin
            errs++; $display("FAIL prio_init_writes: got count=%0d want %0d", wq.size(), SIZE);
        end
        iter_model = 0;
        init_rv = rv_cyc;
        wq.delete();
        rand_data();
        stream(1'b1, 2, SIZE, to);
        wait_done(to2);
        iter_model = (iter_model < 255) ? iter_model + 1 : 255;
        checks++;
        if (urdy_rise_cyc != init_rv + 2) begin
            errs++; $display("FAIL prio_upd_start: got lag=%0d want 2", urdy_rise_cyc - init_rv);
        end
        checks++;
        if (to || to2 || rv_src !== 1'b1 || wq.size() != SIZE) begin
            errs++; $display("FAIL prio_upd_job: got timeout=%b src=%b count=%0d want 0 1 %0d", to | to2, rv_src, wq.size(), SIZE);
        end
        for (int i = 0; i < SIZE && i < wq.size(); i++) begin
            checks++;
            if ({wq[i].a, wq[i].d} !== {ADDR_W'(i), jd[i]}) begin
                errs++; $display("FAIL prio_upd_write[%0d]: got addr=%0d data=%0h want addr=%0d data=%0h", i, wq[i].a, wq[i].d, i, jd[i]);
            end
        end
        checks++;
        if (iter_cnt !== 8'(iter_model)) begin errs++; $display("FAIL prio_iter: got %0d want %0d", iter_cnt, iter_model); end
    endtask

    task automatic test_gaps();
        logic to, to2;
        int r0;
        rand_data();
        wq.delete(); r0 = rd_cnt;
        pulse(1'b0, 1'b1, 1'b0);
        stream(1'b1, 1, SIZE, to);
        wait_done(to2);
        iter_model = (iter_model < 255) ? iter_model + 1 : 255;
        checks++;
        if (to || to2 || wq.size() != SIZE) begin
            errs++; $display("FAIL gap_count: got timeout=%b writes=%0d want 0 %0d", to | to2, wq.size(), SIZE);
        end
        for (int i = 0; i < SIZE && i < wq.size(); i++) begin
            checks++;
            if ({wq[i].a, wq[i].d} !== {ADDR_W'(i), jd[i]}) begin
                errs++; $display("FAIL gap_write[%0d]: got addr=%0d data=%0h want addr=%0d data=%0h", i, wq[i].a, wq[i].d, i, jd[i]);
            end
        end
        checks++;
        if (last_wr_cyc - first_wr_cyc != 2 * (SIZE - 1) || follow_viol != 0) begin
            errs++; $display("FAIL gap_timing: got span=%0d stray=%0d want %0d 0", last_wr_cyc - first_wr_cyc, follow_viol, 2 * (SIZE - 1));
        end
        checks++;
        if (rd_cnt - r0 != 1 || rv_src !== 1'b1 || iter_cnt !== 8'(iter_model)) begin
            errs++; $display("FAIL gap_done: got rd=%0d src=%b iter=%0d want 1 1 %0d", rd_cnt - r0, rv_src, iter_cnt, iter_model);
        end
    endtask

    task automatic test_abort();
        logic to, to2;
        int r0, v0;
        rand_data();
        wq.delete(); r0 = rd_cnt; v0 = rv_cnt;
        pulse(1'b0, 1'b1, 1'b0);
        stream(1'b1, 0, 10, to);
        pulse(1'b1, 1'b0, 1'b0);
        upd_valid = 1'b1; upd_data = jd[10]; abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; upd_valid = 1'b0;
        checks++;
        if (to || busy !== 1'b0) begin errs++; $display("FAIL abort_busy: got busy=%b timeout=%b want 0 0", busy, to); end
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (rd_cnt != r0 || rv_cnt != v0) begin
            errs++; $display("FAIL abort_no_done: got rd=%0d rv=%0d want 0 0", rd_cnt - r0, rv_cnt - v0);
        end
        checks++;
        if (busy !== 1'b0) begin errs++; $display("FAIL abort_pend_cleared: got busy=%b want 0", busy); end
        checks++;
        if (wq.size() != 11) begin errs++; $display("FAIL abort_partial: got writes=%0d want 11", wq.size()); end
        for (int i = 0; i < 11 && i < wq.size(); i++) begin
            checks++;
            if ({wq[i].a, wq[i].d} !== {ADDR_W'(i), jd[i]}) begin
                errs++; $display("FAIL abort_write[%0d]: got addr=%0d data=%0h want addr=%0d data=%0h", i, wq[i].a, wq[i].d, i, jd[i]);
            end
        end
        pulse(1'b1, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errs++; $display("FAIL abort_beats_start: got busy=%b want 0", busy); end
        rand_data();
        wq.delete();
        pulse(1'b0, 1'b1, 1'b0);
        stream(1'b1, 2, SIZE, to);
        wait_done(to2);
        iter_model = (iter_model < 255) ? iter_model + 1 : 255;
        checks++;
        if (to || to2 || wq.size() != SIZE || rv_src !== 1'b1) begin
            errs++; $display("FAIL abort_restart: got timeout=%b writes=%0d src=%b want 0 %0d 1", to | to2, wq.size(), rv_src, SIZE);
        end
        for (int i = 0; i < SIZE && i < wq.size(); i++) begin
            checks++;
            if ({wq[i].a, wq[i].d} !== {ADDR_W'(i), jd[i]}) begin
                errs++; $display("FAIL abort_restart_write[%0d]: got addr=%0d data=%0h want addr=%0d data=%0h", i, wq[i].a, wq[i].d, i, jd[i]);
            end
        end
        checks++;
        if (iter_cnt !== 8'(iter_model)) begin errs++; $display("FAIL abort_iter: got %0d want %0d", iter_cnt, iter_model); end
    endtask

    task automatic test_saturate();
        logic to, to2;
        int jobs = 258 - iter_model;
        for (int j = 0; j < jobs; j++) begin
            rand_data();
            wq.delete();
            pulse(1'b0, 1'b1, 1'b0);
            stream(1'b1, 0, SIZE, to);
            wait_done(to2);
            iter_model = (iter_model < 255) ? iter_model + 1 : 255;
            checks++;
            if (to || to2 || iter_cnt !== 8'(iter_model)) begin
                errs++; $display("FAIL sat_iter[%0d]: got iter=%0d timeout=%b want %0d 0", j, iter_cnt, to | to2, iter_model);
                break;
            end
        end
        checks++;
        if (iter_cnt !== 8'd255) begin errs++; $display("FAIL sat_final: got %0d want 255", iter_cnt); end
        rand_data();
        pulse(1'b1, 1'b0, 1'b0);
        stream(1'b0, 2, SIZE, to);
        wait_done(to2);
        iter_model = 0;
        checks++;
        if (to || to2 || iter_cnt !== 8'(iter_model) || rv_src !== 1'b0) begin
            errs++; $display("FAIL sat_init_clear: got iter=%0d src=%b timeout=%b want 0 0 0", iter_cnt, rv_src, to | to2);
        end
    endtask

    task automatic test_rst_midjob();
        logic to;
        int bad = 0;
        for (int i = 0; i < SIZE; i++) jd[i] = DATA_W'(i + 1);
        pulse(1'b1, 1'b0, 1'b0);
        stream(1'b0, 0, 5, to);
        init_valid = 1'b1;
        rst = 1'b1;
        wq.delete();
        #1;
        iter_model = 0;
        checks++;
        if (to || {wr_en, rd_en, res_valid, res_src, busy, init_ready, upd_ready} !== 7'b0 ||
            {wr_addr, wr_data, iter_cnt} !== '0) begin
            errs++; $display("FAIL rst_async: got flags=%b addr=%0d data=%0h iter=%0d want all 0",
                {wr_en, rd_en, res_valid, res_src, busy, init_ready, upd_ready}, wr_addr, wr_data, iter_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (init_ready !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        init_valid = 1'b0;
        checks++;
        if (bad != 0 || wq.size() != 0) begin
            errs++; $display("FAIL rst_no_resume: got bad_cycles=%0d writes=%0d want 0 0", bad, wq.size());
        end
    endtask

    initial begin
        test_reset();
        test_init_job();
        test_priority();
        test_gaps();
        test_abort();
        test_saturate();
        test_rst_midjob();
        checks++;
        if (excl_viol != 0 || follow_viol != 0) begin
            errs++; $display("FAIL strobe_rules: got overlap=%0d stray_writes=%0d want 0 0", excl_viol, follow_viol);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
